// File: rtl/lcd_pkg.sv
// Shared definitions for the 16x2 HD44780 text driver: commands, default
// timing counts, FSM encodings and small helpers.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_LINE1     = 8'h80;
    localparam logic [7:0] CMD_LINE2     = 8'hC0;

    // Default counts in 50 MHz clock cycles
    localparam int DEF_T_POWERON = 750000;
    localparam int DEF_T_INIT1   = 205000;
    localparam int DEF_T_INIT2   = 5000;
    localparam int DEF_T_CMD     = 2000;
    localparam int DEF_T_CLEAR   = 82000;
    localparam int DEF_T_NIB_GAP = 50;
    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_E_PULSE = 12;
    localparam int DEF_T_HOLD    = 1;

    localparam int WAIT_W     = 20;
    localparam int INIT_STEPS = 8;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        ADDR_A,
        CHARS_A,
        ADDR_B,
        CHARS_B
    } main_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_HOLD,
        TX_WAIT
    } tx_state_e;

    typedef struct packed {
        logic       is_byte;
        logic [7:0] value;
    } init_step_t;

    // Steps 0..3 are lone nibbles of the 8-bit-to-4-bit wake-up; 4..7 full bytes.
    function automatic init_step_t init_rom(input logic [2:0] step);
        init_step_t s;
        s = '{is_byte: 1'b0, value: 8'h00};
        case (step)
            3'd0:    s = '{is_byte: 1'b0, value: 8'h03};
            3'd1:    s = '{is_byte: 1'b0, value: 8'h03};
            3'd2:    s = '{is_byte: 1'b0, value: 8'h03};
            3'd3:    s = '{is_byte: 1'b0, value: 8'h02};
            3'd4:    s = '{is_byte: 1'b1, value: CMD_FUNC_4BIT};
            3'd5:    s = '{is_byte: 1'b1, value: CMD_ENTRY};
            3'd6:    s = '{is_byte: 1'b1, value: CMD_DISP_ON};
            default: s = '{is_byte: 1'b1, value: CMD_CLEAR};
        endcase
        return s;
    endfunction

    // Char 0 is the leftmost and sits in the top byte of the row.
    function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] idx);
        return row[{~idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// Physical LCD bus: enable strobe, register select, read/write and data nibble.
interface lcd_text_driver_if;

    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [3:0] LCD_D;

    modport master (output LCD_E, output LCD_RS, output LCD_RW, output LCD_D);
    modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW, input  LCD_D);

endinterface

// File: rtl/lcd_nibble_tx.sv
// Writes one nibble to the LCD bus: setup, E pulse, hold, then a caller-chosen
// post-wait before signalling done. Owns every E-strobe timing detail.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_E_PULSE = DEF_T_E_PULSE,
    parameter int T_HOLD    = DEF_T_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        nibble,
    input  logic              rs,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic              busy,
    output logic              done,
    output logic              LCD_E,
    output logic [3:0]        LCD_D,
    output logic              LCD_RS
);

    tx_state_e         state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        d_q, d_d;
    logic              rs_q, rs_d;
    logic              e_q, e_d;
    logic              done_q, done_d;

    // E is a flop of its own so an async reset drops it without any decode glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            d_q     <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            d_q     <= d_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        d_d     = d_q;
        rs_d    = rs_q;
        done_d  = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d = TX_SETUP;
                    cnt_d   = WAIT_W'(T_SETUP - 1);
                    d_d     = nibble;
                    rs_d    = rs;
                    wait_d  = wait_cycles;
                end
            end
            TX_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = TX_PULSE;
                    cnt_d   = WAIT_W'(T_E_PULSE - 1);
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            TX_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = TX_HOLD;
                    cnt_d   = WAIT_W'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            TX_HOLD: begin
                if (cnt_q == '0) begin
                    if (wait_q == '0) begin
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = TX_WAIT;
                        cnt_d   = wait_q - WAIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            TX_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = TX_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
        e_d = (state_d == TX_PULSE);
    end

    assign busy   = (state_q != TX_IDLE);
    assign done   = done_q;
    assign LCD_E  = e_q;
    assign LCD_D  = d_q;
    assign LCD_RS = rs_q;

endmodule

// File: rtl/lcd_text_driver.sv
// Runs the HD44780 4-bit power-on init once, then refreshes both 16-char lines
// forever from rows snapshotted at the start of each frame.
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int T_POWERON = DEF_T_POWERON,
    parameter int T_INIT1   = DEF_T_INIT1,
    parameter int T_INIT2   = DEF_T_INIT2,
    parameter int T_CMD     = DEF_T_CMD,
    parameter int T_CLEAR   = DEF_T_CLEAR,
    parameter int T_NIB_GAP = DEF_T_NIB_GAP,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_E_PULSE = DEF_T_E_PULSE,
    parameter int T_HOLD    = DEF_T_HOLD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [127:0]              row_A,
    input  logic [127:0]              row_B,
    lcd_text_driver_if.master         lcd,
    output logic                      init_done,
    output logic                      frame_done
);

    main_state_e       state_q, state_d;
    logic [WAIT_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [2:0]        init_step_q, init_step_d;
    logic [3:0]        char_idx_q, char_idx_d;
    logic              nib_lo_q, nib_lo_d;
    logic              pending_q, pending_d;
    logic              init_done_q, init_done_d;
    logic              frame_done_q, frame_done_d;
    logic [127:0]      snap_a_q, snap_b_q;

    init_step_t        step;
    logic [7:0]        cur_byte;
    logic              cur_rs;
    logic              single;
    logic              item_done;
    logic              snap_load;
    logic              tx_start;
    logic [3:0]        tx_nibble;
    logic [WAIT_W-1:0] tx_wait;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_e;
    logic              tx_rs;
    logic [3:0]        tx_d;

    lcd_nibble_tx #(
        .T_SETUP  (T_SETUP),
        .T_E_PULSE(T_E_PULSE),
        .T_HOLD   (T_HOLD)
    ) u_tx (
        .clk        (clk),
        .reset      (reset),
        .start      (tx_start),
        .nibble     (tx_nibble),
        .rs         (cur_rs),
        .wait_cycles(tx_wait),
        .busy       (tx_busy),
        .done       (tx_done),
        .LCD_E      (tx_e),
        .LCD_D      (tx_d),
        .LCD_RS     (tx_rs)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PWR_WAIT;
            pwr_cnt_q    <= '0;
            init_step_q  <= '0;
            char_idx_q   <= '0;
            nib_lo_q     <= 1'b0;
            pending_q    <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            init_step_q  <= init_step_d;
            char_idx_q   <= char_idx_d;
            nib_lo_q     <= nib_lo_d;
            pending_q    <= pending_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Snapshots are pure data; they are always reloaded before first use.
    always_ff @(posedge clk) begin
        if (snap_load) begin
            snap_a_q <= row_A;
            snap_b_q <= row_B;
        end
    end

    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        init_step_d  = init_step_q;
        char_idx_d   = char_idx_q;
        nib_lo_d     = nib_lo_q;
        pending_d    = pending_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        tx_start     = 1'b0;
        item_done    = 1'b0;
        cur_byte     = 8'h00;
        cur_rs       = 1'b0;
        single       = 1'b0;
        step         = init_rom(init_step_q);

        unique case (state_q)
            INIT: begin
                cur_byte = step.value;
                single   = !step.is_byte;
            end
            ADDR_A:  cur_byte = CMD_LINE1;
            CHARS_A: begin
                cur_byte = row_char(snap_a_q, char_idx_q);
                cur_rs   = 1'b1;
            end
            ADDR_B:  cur_byte = CMD_LINE2;
            CHARS_B: begin
                cur_byte = row_char(snap_b_q, char_idx_q);
                cur_rs   = 1'b1;
            end
            default: ;
        endcase

        tx_nibble = (single || nib_lo_q) ? cur_byte[3:0] : cur_byte[7:4];

        // Only a clear command (RS=0) needs the long settle; a 0x01 char does not.
        if (single) begin
            case (init_step_q)
                3'd0:    tx_wait = WAIT_W'(T_INIT1);
                3'd1:    tx_wait = WAIT_W'(T_INIT2);
                default: tx_wait = WAIT_W'(T_CMD);
            endcase
        end else if (!nib_lo_q) begin
            tx_wait = WAIT_W'(T_NIB_GAP);
        end else if (!cur_rs && cur_byte == CMD_CLEAR) begin
            tx_wait = WAIT_W'(T_CLEAR);
        end else begin
            tx_wait = WAIT_W'(T_CMD);
        end

        if (state_q == PWR_WAIT) begin
            if (pwr_cnt_q == WAIT_W'(T_POWERON - 1)) begin
                state_d = INIT;
            end else begin
                pwr_cnt_d = pwr_cnt_q + WAIT_W'(1);
            end
        end else if (!pending_q) begin
            tx_start  = !tx_busy;
            pending_d = !tx_busy;
        end else if (tx_done) begin
            pending_d = 1'b0;
            if (!single && !nib_lo_q) begin
                nib_lo_d = 1'b1;
            end else begin
                nib_lo_d  = 1'b0;
                item_done = 1'b1;
            end
        end

        if (item_done) begin
            unique case (state_q)
                INIT: begin
                    if (init_step_q == 3'(INIT_STEPS - 1)) begin
                        state_d     = ADDR_A;
                        init_done_d = 1'b1;
                    end else begin
                        init_step_d = init_step_q + 3'd1;
                    end
                end
                ADDR_A: state_d = CHARS_A;
                CHARS_A: begin
                    char_idx_d = char_idx_q + 4'd1;
                    if (char_idx_q == 4'd15) state_d = ADDR_B;
                end
                ADDR_B: state_d = CHARS_B;
                CHARS_B: begin
                    char_idx_d = char_idx_q + 4'd1;
                    if (char_idx_q == 4'd15) begin
                        state_d      = ADDR_A;
                        frame_done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        snap_load = (state_d == ADDR_A) && (state_q != ADDR_A);
    end

    assign lcd.LCD_E   = tx_e;
    assign lcd.LCD_RS  = tx_rs;
    assign lcd.LCD_D   = tx_d;
    assign lcd.LCD_RW  = 1'b0;
    assign init_done   = init_done_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver with scaled timing: init sequence, frame
// contents, snapshot behaviour, E-strobe timing and async reset mid-pulse.
module tb_lcd_text_driver;

    localparam int T_POWERON = 20;
    localparam int T_INIT1   = 10;
    localparam int T_INIT2   = 8;
    localparam int T_CMD     = 6;
    localparam int T_CLEAR   = 9;
    localparam int T_NIB_GAP = 3;
    localparam int T_SETUP   = 2;
    localparam int T_E_PULSE = 12;
    localparam int T_HOLD    = 1;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] row_A;
    logic [127:0] row_B;
    logic         init_done;
    logic         frame_done;

    lcd_text_driver_if lcd();

    lcd_text_driver #(
        .T_POWERON(T_POWERON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
        .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .T_NIB_GAP(T_NIB_GAP),
        .T_SETUP(T_SETUP), .T_E_PULSE(T_E_PULSE), .T_HOLD(T_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_A     (row_A),
        .row_B     (row_B),
        .lcd       (lcd),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] plog[$];
    int         fd_at[$];
    logic [3:0] init_nib[12];
    logic [7:0] ea[16];
    logic [7:0] eb[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: logs {RS,D} at every E rise and checks strobe timing.
    int         stable = 0;
    int         e_len  = 0;
    int         gap    = 100;
    int         rw_bad = 0;
    logic       prev_e = 1'b0;
    logic [4:0] prev_dr = '0;
    logic [4:0] cur_dr;

    always @(negedge clk) begin
        if (!reset) begin
            prev_e  = 1'b0;
            prev_dr = '0;
            stable  = 0;
            e_len   = 0;
            gap     = 100;
        end else begin
            cur_dr = {lcd.LCD_RS, lcd.LCD_D};
            if (lcd.LCD_RW !== 1'b0) rw_bad++;
            if (cur_dr == prev_dr) stable++;
            else stable = 1;
            if (lcd.LCD_E && !prev_e) begin
                chk("setup", (stable >= T_SETUP + 1), 1);
                chk("gap", (gap >= T_NIB_GAP), 1);
                plog.push_back(cur_dr);
                e_len = 1;
            end else if (lcd.LCD_E) begin
                e_len++;
                chk("d_stable_e", cur_dr, prev_dr);
            end else if (prev_e) begin
                chk("e_width", e_len, T_E_PULSE);
                chk("hold", cur_dr, prev_dr);
                gap = 1;
            end else begin
                gap++;
            end
            prev_e  = lcd.LCD_E;
            prev_dr = cur_dr;
        end
    end

    int fd_len = 0;
    always @(negedge clk) begin
        if (!reset) begin
            fd_len = 0;
        end else if (frame_done) begin
            fd_len++;
            if (fd_len == 1) fd_at.push_back(plog.size());
        end else if (fd_len > 0) begin
            chk("fd_width", fd_len, 1);
            fd_len = 0;
        end
    end

    function automatic logic [4:0] exp_frame(input int j);
        int         b;
        logic [7:0] by;
        logic       rs;
        b = j / 2;
        if (b == 0) begin
            by = 8'h80; rs = 1'b0;
        end else if (b <= 16) begin
            by = ea[b-1]; rs = 1'b1;
        end else if (b == 17) begin
            by = 8'hC0; rs = 1'b0;
        end else begin
            by = eb[b-18]; rs = 1'b1;
        end
        return {rs, (j % 2 == 0) ? by[7:4] : by[3:0]};
    endfunction

    task automatic set_exp(input string sa, input string sb);
        for (int i = 0; i < 16; i++) begin
            ea[i] = (sa.len() == 16) ? sa[i] : 8'h00;
            eb[i] = (sb.len() == 16) ? sb[i] : 8'h00;
        end
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (plog.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (plog.size() < n) chk({tag, "_timeout"}, plog.size(), n);
    endtask

    task automatic chk_frame(input int base, input string tag);
        for (int j = 0; j < 68; j++)
            chk($sformatf("%s[%0d]", tag, j),
                (base + j < plog.size()) ? plog[base+j] : 5'h1f, exp_frame(j));
    endtask

    task automatic init_check(input string tag);
        int c;
        repeat (T_POWERON) @(posedge clk);
        @(negedge clk);
        chk({tag, "_quiet"}, plog.size(), 0);
        chk({tag, "_idone0"}, init_done, 0);
        wait_pulses(12, 1000, tag);
        chk({tag, "_idone_early"}, init_done, 0);
        for (int k = 0; k < 12; k++)
            chk($sformatf("%s_nib%0d", tag, k),
                (k < plog.size()) ? plog[k] : 5'h1f, {1'b0, init_nib[k]});
        c = 0;
        while (!init_done && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_idone_lat"}, (c >= 22 && c <= 24), 1);
    endtask

    initial begin
        int c;
        init_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        row_A = "Prime #01 is 002";
        row_B = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_E", lcd.LCD_E, 0);
        chk("rst_RS", lcd.LCD_RS, 0);
        chk("rst_RW", lcd.LCD_RW, 0);
        chk("rst_D", lcd.LCD_D, 0);
        chk("rst_idone", init_done, 0);
        chk("rst_fdone", frame_done, 0);
        @(negedge clk) reset = 1'b1;

        init_check("init1");
        set_exp("Prime #01 is 002", "");

        // Change row_B once CHARS_A is under way; this frame must not see it.
        wait_pulses(12 + 4, 400, "f1_start");
        row_B = "ABCDEFGHIJKLMNOP";
        wait_pulses(12 + 68, 3000, "f1");
        chk("f1_h0", plog[12], 5'h08);
        chk("f1_h1", plog[13], 5'h00);
        chk("f1_h2", plog[14], 5'h15);
        chk("f1_h3", plog[15], 5'h10);
        chk("f1_h4", plog[16], 5'h17);
        chk("f1_h5", plog[17], 5'h12);
        chk("f1_h6", plog[18], 5'h16);
        chk("f1_h7", plog[19], 5'h19);
        chk_frame(12, "f1");

        set_exp("Prime #01 is 002", "ABCDEFGHIJKLMNOP");
        wait_pulses(12 + 136, 3000, "f2");
        chk_frame(80, "f2");
        wait_pulses(12 + 204, 3000, "f3");
        chk_frame(148, "f3");

        c = 0;
        while (fd_at.size() < 3 && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("fd_count", fd_at.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("fd_at%0d", k), (k < fd_at.size()) ? fd_at[k] : -1, 12 + 68 * (k + 1));

        // Async reset in the middle of an E pulse.
        c = 0;
        while (!lcd.LCD_E && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("e_high_pre_rst", lcd.LCD_E, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_E", lcd.LCD_E, 0);
        chk("mid_rst_idone", init_done, 0);
        chk("mid_rst_D", lcd.LCD_D, 0);
        chk("mid_rst_RS", lcd.LCD_RS, 0);
        chk("mid_rst_fdone", frame_done, 0);
        plog.delete();
        fd_at.delete();
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        init_check("init2");

        chk("rw_low", rw_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
